// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage instruction words in, hold/kill/bypass controls out.
// nop_inst carries the word the pipeline loads into a killed or bubbled register.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instD, instX, instM, instW;
  logic             redirectX;
  logic             stallF, stallD, killD, bubbleX;
  logic [1:0]       bypA;
  logic             bypB, wbfwdA, wbfwdB;
  logic             validX, validM, validW;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [31:0]      nop_inst;

  modport master (
    output instD, instX, instM, instW, redirectX,
    input  stallF, stallD, killD, bubbleX, bypA, bypB, wbfwdA, wbfwdB,
    input  validX, validM, validW, stall_cnt, flush_cnt, nop_inst
  );

  modport slave (
    input  instD, instX, instM, instW, redirectX,
    output stallF, stallD, killD, bubbleX, bypA, bypB, wbfwdA, wbfwdB,
    output validX, validM, validW, stall_cnt, flush_cnt, nop_inst
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: stage valid bits, bypass selects, load-use stall, redirect flush.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_t;

  typedef enum logic [1:0] {
    SRC_RS    = 2'd0,
    SRC_ALUM  = 2'd1,
    SRC_DATAW = 2'd2
  } byp_src_t;

  typedef struct packed {
    logic       wr;
    logic       use1;
    logic       use2;
    logic       load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d     = '0;
    d.rd  = inst[11:7];
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    case (inst[6:0])
      OPC_OP:                      begin d.wr = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; end
      OPC_OPIMM, OPC_JALR:         begin d.wr = 1'b1; d.use1 = 1'b1; end
      OPC_LOAD:                    begin d.wr = 1'b1; d.use1 = 1'b1; d.load = 1'b1; end
      OPC_STORE, OPC_BRANCH:       begin d.use1 = 1'b1; d.use2 = 1'b1; end
      OPC_JAL, OPC_LUI, OPC_AUIPC: d.wr = 1'b1;
      default:                     ;
    endcase
    d.wr = d.wr & (d.rd != '0);
    return d;
  endfunction

  dec_t     dD, dX, dM, dW;
  logic     vD, vX, vM, vW;
  logic     prodM, prodW, hazX, hazM, load_use;
  byp_src_t bypA_src;

  always_comb begin
    dD    = decode(hz.instD);
    dX    = decode(hz.instX);
    dM    = decode(hz.instM);
    dW    = decode(hz.instW);
    prodM = vM & dM.wr;
    prodW = vW & dW.wr;
    // A load still in M cannot be bypassed, so the dependent stays in D until the load reaches W.
    hazX  = vD & vX & dX.wr & dX.load &
            ((dD.use1 & (dD.rs1 == dX.rd)) | (dD.use2 & (dD.rs2 == dX.rd)));
    hazM  = vD & prodM & dM.load &
            ((dD.use1 & (dD.rs1 == dM.rd)) | (dD.use2 & (dD.rs2 == dM.rd)));
    load_use = hazX | hazM;
  end

  always_comb begin
    hz.stallF  = 1'b0;
    hz.stallD  = 1'b0;
    hz.killD   = 1'b0;
    hz.bubbleX = 1'b0;
    hz.bypB    = 1'b0;
    hz.wbfwdA  = 1'b0;
    hz.wbfwdB  = 1'b0;
    bypA_src   = SRC_RS;
    if (rst || hz.redirectX) begin
      hz.killD   = 1'b1;
      hz.bubbleX = 1'b1;
    end else if (load_use) begin
      hz.stallF  = 1'b1;
      hz.stallD  = 1'b1;
      hz.bubbleX = 1'b1;
    end
    if (!rst) begin
      if (vX && dX.use1) begin
        if (prodM && !dM.load && (dM.rd == dX.rs1))
          bypA_src = SRC_ALUM;
        else if (prodW && (dW.rd == dX.rs1))
          bypA_src = SRC_DATAW;
      end
      hz.bypB   = vX & prodM & ~dM.load & (dM.rd == dX.rs2);
      hz.wbfwdA = vD & prodW & dD.use1 & (dW.rd == dD.rs1);
      hz.wbfwdB = vD & prodW & dD.use2 & (dW.rd == dD.rs2);
    end
    hz.bypA = bypA_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vD <= 1'b0;
      vX <= 1'b0;
      vM <= 1'b0;
      vW <= 1'b0;
    end else begin
      vM <= vX;
      vW <= vM;
      if (hz.redirectX) begin
        vD <= 1'b0;
        vX <= 1'b0;
      end else if (load_use) begin
        vX <= 1'b0;
      end else begin
        vD <= 1'b1;
        vX <= vD;
      end
    end
  end

  assign hz.validX   = vX;
  assign hz.validM   = vM;
  assign hz.validW   = vW;
  assign hz.nop_inst = NOP;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hz.redirectX && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
      if (load_use && !hz.redirectX && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a stage-list pipeline model.
module tb_hazard_ctrl;
  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz();
  hazard_ctrl #(.NOP(NOP_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model pipeline: index 0..3 = D, X, M, W
  logic [31:0]     m_inst [4];
  bit              m_v    [4];
  logic [31:0]     fetch_q [$];
  bit              rand_mode = 0;
  longint unsigned m_stall = 0, m_flush = 0;

  logic       obs_stallF, obs_killD, obs_bubbleX, obs_wbfwdA, obs_bypB;
  logic       obs_validX, obs_validM, obs_validW;
  logic [1:0] obs_bypA;
  logic [CNT_W-1:0] obs_stall_cnt, obs_flush_cnt;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction
  function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
    return enc_i(12'd0, rs1, 3'b010, rd, 7'h03);
  endfunction
  function automatic logic [31:0] add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] beq(logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'h63};
  endfunction

  function automatic bit writes_rd(logic [31:0] i);
    return (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17}) && (i[11:7] != 5'd0);
  endfunction
  function automatic bit uses1(logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction
  function automatic bit uses2(logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction
  function automatic bit is_load(logic [31:0] i);
    return i[6:0] == 7'h03;
  endfunction
  function automatic bit reads(logic [31:0] i, logic [4:0] r);
    return (uses1(i) && i[19:15] == r) || (uses2(i) && i[24:20] == r);
  endfunction

  // D waits while any valid load ahead of it in X or M targets one of its sources.
  function automatic bit model_lu();
    if (!m_v[0]) return 0;
    for (int s = 1; s <= 2; s++)
      if (m_v[s] && is_load(m_inst[s]) && writes_rd(m_inst[s]) && reads(m_inst[0], m_inst[s][11:7]))
        return 1;
    return 0;
  endfunction

  function automatic int model_bypA();
    logic [4:0] r;
    if (!(m_v[1] && uses1(m_inst[1]))) return 0;
    r = m_inst[1][19:15];
    if (m_v[2] && writes_rd(m_inst[2]) && !is_load(m_inst[2]) && m_inst[2][11:7] == r) return 1;
    if (m_v[3] && writes_rd(m_inst[3]) && m_inst[3][11:7] == r) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  a, b, c;
    logic [31:0] rn;
    a  = 5'($urandom_range(0, 3));
    b  = 5'($urandom_range(0, 3));
    c  = 5'($urandom_range(0, 3));
    rn = $urandom();
    case ($urandom_range(0, 9))
      0:       return add(a, b, c);
      1:       return addi(a, b, rn[11:0]);
      2, 3:    return lw(a, b);
      4:       return {rn[31:25], c, b, 3'b010, rn[11:7], 7'h23};
      5:       return {rn[31:25], c, b, rn[14:12], rn[11:7], 7'h63};
      6:       return {rn[31:12], a, 7'h6f};
      7:       return enc_i(rn[11:0], b, 3'b000, a, 7'h67);
      8:       return {rn[31:12], a, rn[0] ? 7'h37 : 7'h17};
      default: return rn;
    endcase
  endfunction

  function automatic logic [31:0] next_fetch();
    if (fetch_q.size() > 0) return fetch_q.pop_front();
    return rand_mode ? rand_inst() : NOP_W;
  endfunction

  task automatic run_cycle(input bit r, input bit redir);
    bit   lu, e_stall, e_kill;
    int   e_bypA;
    bit   e_bypB, e_wA, e_wB;
    rst          = r;
    hz.redirectX = redir;
    hz.instD     = m_v[0] ? m_inst[0] : $urandom();
    hz.instX     = m_v[1] ? m_inst[1] : $urandom();
    hz.instM     = m_v[2] ? m_inst[2] : $urandom();
    hz.instW     = m_v[3] ? m_inst[3] : $urandom();
    @(negedge clk);
    lu      = model_lu();
    e_kill  = r || redir;
    e_stall = !e_kill && lu;
    e_bypA  = r ? 0 : model_bypA();
    e_bypB  = !r && m_v[1] && m_v[2] && writes_rd(m_inst[2]) && !is_load(m_inst[2]) &&
              (m_inst[2][11:7] == m_inst[1][24:20]);
    e_wA    = !r && m_v[0] && m_v[3] && writes_rd(m_inst[3]) && uses1(m_inst[0]) &&
              (m_inst[3][11:7] == m_inst[0][19:15]);
    e_wB    = !r && m_v[0] && m_v[3] && writes_rd(m_inst[3]) && uses2(m_inst[0]) &&
              (m_inst[3][11:7] == m_inst[0][24:20]);
    check("stallF",  hz.stallF,  e_stall);
    check("stallD",  hz.stallD,  e_stall);
    check("killD",   hz.killD,   e_kill);
    check("bubbleX", hz.bubbleX, e_kill || e_stall);
    check("bypA",    hz.bypA,    e_bypA);
    check("bypB",    hz.bypB,    e_bypB);
    check("wbfwdA",  hz.wbfwdA,  e_wA);
    check("wbfwdB",  hz.wbfwdB,  e_wB);
    check("validX",  hz.validX,  m_v[1]);
    check("validM",  hz.validM,  m_v[2]);
    check("validW",  hz.validW,  m_v[3]);
    check("stall_cnt", hz.stall_cnt, m_stall);
    check("flush_cnt", hz.flush_cnt, m_flush);
    obs_stallF    = hz.stallF;   obs_killD  = hz.killD;  obs_bubbleX = hz.bubbleX;
    obs_bypA      = hz.bypA;     obs_bypB   = hz.bypB;   obs_wbfwdA  = hz.wbfwdA;
    obs_validX    = hz.validX;   obs_validM = hz.validM; obs_validW  = hz.validW;
    obs_stall_cnt = hz.stall_cnt; obs_flush_cnt = hz.flush_cnt;
    @(posedge clk);
    if (r) begin
      for (int s = 0; s < 4; s++) m_v[s] = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (redir) m_flush++;
      else if (lu) m_stall++;
`endif
      m_v[3] = m_v[2]; m_inst[3] = m_inst[2];
      m_v[2] = m_v[1]; m_inst[2] = m_inst[1];
      if (redir) begin
        m_v[0] = 0;
        m_v[1] = 0;
      end else if (lu) begin
        m_v[1] = 0;
      end else begin
        m_v[1] = m_v[0]; m_inst[1] = m_inst[0];
        m_v[0] = 1;      m_inst[0] = next_fetch();
      end
    end
    #1;
  endtask

  initial begin
    int  cnt_a, cnt_b;
    bit  hit, at;
    logic [31:0] w_beq, w_add5, w_add7, w_lw9, w_add10;
    w_beq = beq(5'd1, 5'd2);  w_add5 = add(5'd5, 5'd0, 5'd0);  w_add7 = add(5'd7, 5'd6, 5'd0);
    w_lw9 = lw(5'd9, 5'd0);   w_add10 = add(5'd10, 5'd9, 5'd0);
    for (int s = 0; s < 4; s++) begin m_v[s] = 0; m_inst[s] = '0; end
    rst = 1'b1; hz.redirectX = 1'b0;
    hz.instD = '0; hz.instX = '0; hz.instM = '0; hz.instW = '0;
    @(posedge clk); #1;

    // reset, then addi x1 / add x2,x1,x1
    run_cycle(1, 0);
    check("rst_killD", obs_killD, 1'b1);
    check("rst_stallF", obs_stallF, 1'b0);
    run_cycle(1, 0);
    fetch_q.push_back(addi(5'd1, 5'd0, 12'd5));
    fetch_q.push_back(add(5'd2, 5'd1, 5'd1));
    repeat (3) run_cycle(0, 0);
    run_cycle(0, 0);
    check("chain_bypA", obs_bypA, 2'd1);
    check("chain_bypB", obs_bypB, 1'b1);
    check("chain_validW_early", obs_validW, 1'b0);
    run_cycle(0, 0);
    check("chain_validW", obs_validW, 1'b1);

    // load-use: lw x3 / add x4,x3,x0
    fetch_q.push_back(lw(5'd3, 5'd0));
    fetch_q.push_back(add(5'd4, 5'd3, 5'd0));
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(0, 0);
      if (obs_stallF) cnt_a++;
      if (obs_wbfwdA) cnt_b++;
    end
    check("lu_stall_cycles", cnt_a, 2);
    check("lu_wbfwdA_cycles", cnt_b, 1);
`ifdef HAZARD_PERF_EN
    check("lu_stall_cnt", obs_stall_cnt, 2);
`endif

    // taken beq in X with a dependent in D
    fetch_q.push_back(w_beq);
    fetch_q.push_back(add(5'd8, 5'd1, 5'd0));
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      at = m_v[1] && (m_inst[1] == w_beq);
      run_cycle(0, at);
      if (at) begin
        hit = 1;
        check("redir_killD", obs_killD, 1'b1);
        check("redir_bubbleX", obs_bubbleX, 1'b1);
        check("redir_stallF", obs_stallF, 1'b0);
        run_cycle(0, 0);
        check("redir_validX", obs_validX, 1'b0);
`ifdef HAZARD_PERF_EN
        check("redir_flush_cnt", obs_flush_cnt, 1);
`endif
      end
    end
    check("redir_reached", hit, 1'b1);

    // x0 destination load never stalls or bypasses
    fetch_q.push_back(lw(5'd0, 5'd0));
    fetch_q.push_back(w_add5);
    cnt_a = 0; hit = 0;
    for (int k = 0; k < 8; k++) begin
      at = m_v[1] && (m_inst[1] == w_add5);
      run_cycle(0, 0);
      if (obs_stallF) cnt_a++;
      if (at) begin
        hit = 1;
        check("x0_bypA", obs_bypA, 2'd0);
        check("x0_bypB", obs_bypB, 1'b0);
      end
    end
    check("x0_stalls", cnt_a, 0);
    check("x0_reached", hit, 1'b1);

    // W -> D forward
    fetch_q.push_back(addi(5'd6, 5'd0, 12'd7));
    fetch_q.push_back(NOP_W);
    fetch_q.push_back(NOP_W);
    fetch_q.push_back(w_add7);
    hit = 0;
    for (int k = 0; k < 10; k++) begin
      at = m_v[0] && (m_inst[0] == w_add7);
      run_cycle(0, 0);
      if (at) begin
        hit = 1;
        check("wb_fwdA", obs_wbfwdA, 1'b1);
      end
    end
    check("wb_reached", hit, 1'b1);

    // reset in the middle of a load-use stall
    fetch_q.push_back(w_lw9);
    fetch_q.push_back(w_add10);
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      at = m_v[1] && (m_inst[1] == w_lw9) && m_v[0] && (m_inst[0] == w_add10);
      run_cycle(at, 0);
      if (at) begin
        hit = 1;
        run_cycle(0, 0);
        check("mrst_validX", obs_validX, 1'b0);
        check("mrst_validM", obs_validM, 1'b0);
        check("mrst_validW", obs_validW, 1'b0);
        check("mrst_stallF", obs_stallF, 1'b0);
        check("mrst_stall_cnt", obs_stall_cnt, 0);
        check("mrst_flush_cnt", obs_flush_cnt, 0);
      end
    end
    check("mrst_reached", hit, 1'b1);

    // random traffic with occasional redirects and resets
    rand_mode = 1;
    for (int k = 0; k < 3000; k++)
      run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
